// File: rtl/quad_phase_pkg.sv
// Shared types for the quadrature phase monitor: FSM states,
// phase indices, sample encodings and the sample-to-phase decode.
package quad_phase_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  // Sample order is {div4_0, div4_90}.
  localparam logic [1:0] S_PH0 = 2'b00;
  localparam logic [1:0] S_PH1 = 2'b10;
  localparam logic [1:0] S_PH2 = 2'b11;
  localparam logic [1:0] S_PH3 = 2'b01;

  function automatic logic [1:0] phase_of(
    input logic [1:0] s
  );
    logic [1:0] p;
    p = PH0;
    unique case (1'b1)
      (s == S_PH0): p = PH0;
      (s == S_PH1): p = PH1;
      (s == S_PH2): p = PH2;
      (s == S_PH3): p = PH3;
      default:      p = PH0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/quad_phase_monitor_if.sv
// Bundle between the divider side (master) and the monitor (slave).
// Carries the div4 pair, clear, and all monitor status outputs.
interface quad_phase_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clock_div4_0;
  logic             clock_div4_90;
  logic             clear;
  logic [1:0]       phase;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output clock_div4_0, clock_div4_90, clear,
    input  phase, locked, err_pulse,
    input  err_sticky, cycle_count
  );

  modport slave (
    input  clock_div4_0, clock_div4_90, clear,
    output phase, locked, err_pulse,
    output err_sticky, cycle_count
  );
endinterface

// File: rtl/quad_step_decode.sv
// Classifies one step of the div4 pair: prev_i/s_i in,
// good_o (phase+1), wrap_o (good 3->0), phase_o (phase of s_i) out.
module quad_step_decode
  import quad_phase_pkg::*;
(
  input  logic [1:0] prev_i,
  input  logic [1:0] s_i,
  output logic       good_o,
  output logic       wrap_o,
  output logic [1:0] phase_o
);
  logic [1:0] pp;
  logic [1:0] pp_inc;

  assign pp      = phase_of(prev_i);
  assign pp_inc  = pp + 2'd1;
  assign phase_o = phase_of(s_i);
  assign good_o  = (phase_o == pp_inc);
  assign wrap_o  = good_o && (pp == PH3);
endmodule

// File: rtl/quad_phase_monitor.sv
// Lock/error monitor for the quadrature div4 clock pair.
// Ports: clock_in, reset (async high), bus (slave modport).
module quad_phase_monitor
  import quad_phase_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input logic           clock_in,
  input logic           reset,
  quad_phase_monitor_if.slave bus
);
  localparam int GOAL = 4 * LOCK_COUNT;
  localparam int GW   = $clog2(GOAL + 1);

  logic [1:0]       s;
  logic [1:0]       ph;
  logic             good;
  logic             wrap;
  logic             step_good;
  logic             step_bad;
  logic             cnt_hit;

  state_e           state_q, state_d;
  logic [1:0]       prev_q;
  logic             prev_valid_q;
  logic [1:0]       phase_q;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s = {bus.clock_div4_0, bus.clock_div4_90};

  quad_step_decode u_dec (
    .prev_i  (prev_q),
    .s_i     (s),
    .good_o  (good),
    .wrap_o  (wrap),
    .phase_o (ph)
  );

  // No step exists until prev holds a real sample.
  assign step_good = prev_valid_q & good;
  assign step_bad  = prev_valid_q & ~good;
  assign cnt_hit   = (good_cnt_q == GW'(GOAL - 1));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state_q <= ACQUIRE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACQUIRE: if (step_good && cnt_hit) state_d = LOCKED;
      LOCKED:  if (step_bad)             state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
  end

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    if (step_bad) begin
      good_cnt_d = '0;
    end else if (step_good && state_q == ACQUIRE) begin
      good_cnt_d = good_cnt_q + GW'(1);
    end
    if (state_q == LOCKED) begin
      err_d = step_bad;
      if (step_good && wrap) cnt_d = cnt_q + CNT_W'(1);
    end
    // clear beats a same-edge increment, a same-edge error beats clear.
    if (bus.clear) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (err_d) sticky_d = 1'b1;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      phase_q      <= PH0;
      good_cnt_q   <= '0;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      prev_q       <= s;
      prev_valid_q <= 1'b1;
      phase_q      <= ph;
      good_cnt_q   <= good_cnt_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_pulse   = err_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_quad_phase_monitor.sv
// Self-checking bench for quad_phase_monitor: directed scenarios
// plus randomized steps compared against a phase-arithmetic model.
module tb_quad_phase_monitor;
  localparam int LC = 4;
  localparam int CW = 4;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;

  quad_phase_monitor_if #(.CNT_W(CW)) bus ();

  quad_phase_monitor #(
    .LOCK_COUNT (LC),
    .CNT_W      (CW)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  int checks   = 0;
  int failures = 0;
  int gph      = 0;

  // Model state: last phase, validity, run of good steps, outputs.
  int m_pp, m_run, m_cnt, m_ph;
  bit m_pv, m_lk, m_err, m_st;

  function automatic logic [1:0] smp(input int p);
    logic [1:0] t [4];
    t = '{2'b00, 2'b10, 2'b11, 2'b01};
    return t[p % 4];
  endfunction

  function automatic int dec(input logic [1:0] s);
    for (int i = 0; i < 4; i++)
      if (smp(i) == s) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pp = 0; m_run = 0; m_cnt = 0; m_ph = 0;
    m_pv = 0; m_lk = 0; m_err = 0; m_st = 0;
  endtask

  // Drive one sample, take one edge, advance the model, settle.
  task automatic tick(input logic [1:0] s, input logic c);
    int  p;
    bit  good;
    bit  was_lk;
    bus.clock_div4_0  = s[1];
    bus.clock_div4_90 = s[0];
    bus.clear         = c;
    @(posedge clock_in);
    p      = dec(s);
    was_lk = m_lk;
    m_err  = 0;
    if (m_pv) begin
      good = ((p - m_pp + 4) % 4) == 1;
      if (good) begin
        if (was_lk && p == 0) m_cnt = (m_cnt + 1) % (1 << CW);
        if (!was_lk) begin
          m_run++;
          if (m_run == 4 * LC) m_lk = 1;
        end
      end else begin
        m_run = 0;
        if (was_lk) begin
          m_err = 1;
          m_lk  = 0;
        end
      end
    end
    if (c) begin
      m_cnt = 0;
      m_st  = 0;
    end
    if (m_err) m_st = 1;
    m_pp = p; m_pv = 1; m_ph = p;
    #1;
  endtask

  task automatic good_step(input logic c);
    tick(smp(gph), c);
    gph = (gph + 1) % 4;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock_in);
    #1;
    reset = 1'b0;
    gph   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock_in);
    #1;
    checks++;
    if ({bus.phase, bus.locked, bus.err_pulse, bus.err_sticky,
         bus.cycle_count} !== '0) begin
      failures++;
      $display("FAIL reset_state got ph=%0d lk=%b ep=%b es=%b cc=%0d want 0",
        bus.phase, bus.locked, bus.err_pulse, bus.err_sticky,
        bus.cycle_count);
    end
    reset = 1'b0;
    gph   = 0;
  endtask

  task automatic test_clean_lock();
    for (int e = 1; e <= 20; e++) begin
      good_step(1'b0);
      checks++;
      if (bus.locked !== (e >= 17)) begin
        failures++;
        $display("FAIL clean_lock edge %0d locked=%b want %b",
          e, bus.locked, (e >= 17));
      end
      checks++;
      if (bus.phase !== 2'((e - 1) % 4)) begin
        failures++;
        $display("FAIL clean_phase edge %0d phase=%0d want %0d",
          e, bus.phase, (e - 1) % 4);
      end
      checks++;
      if (bus.err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL clean_err edge %0d err_pulse=%b want 0",
          e, bus.err_pulse);
      end
    end
  endtask

  task automatic test_hold_fault();
    tick(smp((gph + 3) % 4), 1'b0);
    checks++;
    if ({bus.err_pulse, bus.err_sticky, bus.locked} !== 3'b110) begin
      failures++;
      $display("FAIL hold_fault ep/es/lk=%b%b%b want 110",
        bus.err_pulse, bus.err_sticky, bus.locked);
    end
    for (int k = 1; k <= 17; k++) begin
      good_step(1'b0);
      checks++;
      if (bus.locked !== (k >= 16) || bus.err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL hold_relock step %0d lk=%b ep=%b want %b 0",
          k, bus.locked, bus.err_pulse, (k >= 16));
      end
    end
  endtask

  task automatic test_reverse();
    do_reset();
    for (int e = 0; e < 40; e++) begin
      tick(smp((4 - (e % 4)) % 4), 1'b0);
      checks++;
      if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 ||
          bus.cycle_count !== '0) begin
        failures++;
        $display("FAIL reverse edge %0d lk=%b ep=%b cc=%0d want 0 0 0",
          e, bus.locked, bus.err_pulse, bus.cycle_count);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    repeat (17) good_step(1'b0);
    checks++;
    if (bus.locked !== 1'b1 || bus.cycle_count !== '0) begin
      failures++;
      $display("FAIL wrap_lock_edge lk=%b cc=%0d want 1 0",
        bus.locked, bus.cycle_count);
    end
    n = 0;
    while (n < 17) begin
      if (gph == 0) n++;
      good_step(1'b0);
      checks++;
      if (bus.cycle_count !== CW'(n % 16)) begin
        failures++;
        $display("FAIL wrap_count n=%0d cc=%0d want %0d",
          n, bus.cycle_count, n % 16);
      end
    end
    checks++;
    if (bus.cycle_count !== CW'(1)) begin
      failures++;
      $display("FAIL wrap_final cc=%0d want 1", bus.cycle_count);
    end
  endtask

  task automatic test_clear_vs_error();
    int q;
    while (bus.cycle_count !== CW'(5)) good_step(1'b0);
    q = (gph + 1) % 4;
    tick(smp(q), 1'b1);
    gph = (q + 1) % 4;
    checks++;
    if ({bus.err_sticky, bus.locked, bus.err_pulse} !== 3'b101 ||
        bus.cycle_count !== '0) begin
      failures++;
      $display("FAIL clear_vs_err es/lk/ep=%b%b%b cc=%0d want 101 0",
        bus.err_sticky, bus.locked, bus.err_pulse, bus.cycle_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (17) good_step(1'b0);
    for (int w = 0; w < 200 && bus.cycle_count !== CW'(9); w++)
      good_step(1'b0);
    good_step(1'b0);
    checks++;
    if (bus.locked !== 1'b1 || bus.cycle_count !== CW'(9)) begin
      failures++;
      $display("FAIL async_setup lk=%b cc=%0d want 1 9",
        bus.locked, bus.cycle_count);
    end
    #2 reset = 1'b1;
    #2;
    checks++;
    if ({bus.phase, bus.locked, bus.err_pulse, bus.err_sticky,
         bus.cycle_count} !== '0) begin
      failures++;
      $display("FAIL async_reset ph=%0d lk=%b cc=%0d want 0 0 0",
        bus.phase, bus.locked, bus.cycle_count);
    end
    #1 reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 18; e++) begin
      good_step(1'b0);
      checks++;
      if (bus.locked !== (e >= 17)) begin
        failures++;
        $display("FAIL async_relock edge %0d locked=%b want %b",
          e, bus.locked, (e >= 17));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] s;
    logic       c;
    do_reset();
    for (int e = 0; e < 800; e++) begin
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 24) == 0) s = 2'($urandom_range(0, 3));
      else                            s = smp(gph);
      tick(s, c);
      gph = (dec(s) + 1) % 4;
      checks++;
      if (bus.phase !== 2'(m_ph) || bus.locked !== m_lk ||
          bus.err_pulse !== m_err || bus.err_sticky !== m_st ||
          bus.cycle_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL random edge %0d got %0d/%b/%b/%b/%0d want %0d/%b/%b/%b/%0d",
          e, bus.phase, bus.locked, bus.err_pulse, bus.err_sticky,
          bus.cycle_count, m_ph, m_lk, m_err, m_st, m_cnt);
      end
    end
  endtask

  initial begin
    bus.clock_div4_0  = 1'b0;
    bus.clock_div4_90 = 1'b0;
    bus.clear         = 1'b0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_hold_fault();
    test_reverse();
    test_wrap();
    test_clear_vs_error();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
